// File: rtl/dma_copy_engine.sv
// Wishbone memory-to-memory word-copy DMA master with a small CSR slave port.
// Alternates single-word reads and writes, idling one cycle after each ack.
module dma_copy_engine #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cfg_stb_i,
  input  logic        cfg_cyc_i,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_adr_i,
  input  logic [31:0] cfg_dat_i,
  output logic        cfg_ack_o,
  output logic [31:0] cfg_dat_o,
  output logic        dma_stb_o,
  output logic        dma_cyc_o,
  output logic        dma_we_o,
  output logic [3:0]  dma_sel_o,
  output logic [31:0] dma_adr_o,
  output logic [31:0] dma_dat_o,
  input  logic        dma_ack_i,
  input  logic [31:0] dma_dat_i,
  output logic        irq_o
);

  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_GAP1,
    ST_WR,
    ST_GAP2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [31:0]        buf_q, buf_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ie_q, ie_d;
  logic               cfg_ack_q, cfg_ack_d;
  logic [31:0]        cfg_dat_q, cfg_dat_d;
  logic               dma_stb_q, dma_stb_d;
  logic               dma_we_q, dma_we_d;
  logic [31:0]        dma_adr_q, dma_adr_d;
  logic [31:0]        dma_dat_q, dma_dat_d;

  logic               cfg_req, cfg_wr, busy, start, abort;
  logic [1:0]         reg_sel;
  logic               unused_adr_bits;

  assign unused_adr_bits = ^cfg_adr_i[1:0];

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    buf_d     = buf_q;
    timer_d   = '0;
    done_d    = done_q;
    err_d     = err_q;
    ie_d      = ie_q;
    cfg_dat_d = '0;
    abort     = 1'b0;

    busy      = (state_q != ST_IDLE);
    reg_sel   = cfg_adr_i[3:2];
    cfg_req   = cfg_stb_i & cfg_cyc_i & ~cfg_ack_q;
    cfg_wr    = cfg_req & cfg_we_i;
    cfg_ack_d = cfg_req;
    start     = cfg_wr && (reg_sel == 2'd0) && cfg_dat_i[0];

    // Read data reflects register state before this access's write lands.
    if (cfg_req) begin
      case (reg_sel)
        2'd0:    cfg_dat_d = {28'b0, err_q, ie_q, done_q, busy};
        2'd1:    cfg_dat_d = src_q;
        2'd2:    cfg_dat_d = dst_q;
        default: cfg_dat_d = 32'(len_q);
      endcase
    end

    if (cfg_wr) begin
      case (reg_sel)
        2'd0: begin
          ie_d = cfg_dat_i[2];
          if (cfg_dat_i[1]) begin
            done_d = 1'b0;
            err_d  = 1'b0;
          end
        end
        2'd1:    if (!busy) src_d = {cfg_dat_i[31:2], 2'b00};
        2'd2:    if (!busy) dst_d = {cfg_dat_i[31:2], 2'b00};
        default: if (!busy) len_d = cfg_dat_i[LEN_W-1:0];
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d = (len_q == '0);
          err_d  = 1'b0;
          if (len_q != '0) state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (dma_ack_i) begin
          buf_d   = dma_dat_i;
          state_d = ST_GAP1;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_GAP1: state_d = ST_WR;
      ST_WR: begin
        if (dma_ack_i) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          len_d   = len_q - 1'b1;
          state_d = ST_GAP2;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_GAP2: begin
        if (len_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      done_d  = 1'b1;
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end

    // Master outputs are registered from the next state so they are stable across waits.
    dma_stb_d = (state_d == ST_RD) || (state_d == ST_WR);
    dma_we_d  = (state_d == ST_WR);
    dma_adr_d = (state_d == ST_RD) ? src_d : ((state_d == ST_WR) ? dst_d : 32'd0);
    dma_dat_d = (state_d == ST_WR) ? buf_d : 32'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      buf_q     <= '0;
      timer_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ie_q      <= 1'b0;
      cfg_ack_q <= 1'b0;
      cfg_dat_q <= '0;
      dma_stb_q <= 1'b0;
      dma_we_q  <= 1'b0;
      dma_adr_q <= '0;
      dma_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      buf_q     <= buf_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ie_q      <= ie_d;
      cfg_ack_q <= cfg_ack_d;
      cfg_dat_q <= cfg_dat_d;
      dma_stb_q <= dma_stb_d;
      dma_we_q  <= dma_we_d;
      dma_adr_q <= dma_adr_d;
      dma_dat_q <= dma_dat_d;
    end
  end

  assign cfg_ack_o = cfg_ack_q;
  assign cfg_dat_o = cfg_dat_q;
  assign dma_stb_o = dma_stb_q;
  assign dma_cyc_o = dma_stb_q;
  assign dma_we_o  = dma_we_q;
  assign dma_sel_o = {4{dma_stb_q}};
  assign dma_adr_o = dma_adr_q;
  assign dma_dat_o = dma_dat_q;
  assign irq_o     = done_q & ie_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed self-checking bench for dma_copy_engine: CSR access, copy sequence,
// zero-length start, bus timeout, busy write protection, address wrap and reset.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_stb_i, cfg_cyc_i, cfg_we_i;
  logic [3:0]  cfg_adr_i;
  logic [31:0] cfg_dat_i;
  logic        cfg_ack_o;
  logic [31:0] cfg_dat_o;
  logic        dma_stb_o, dma_cyc_o, dma_we_o;
  logic [3:0]  dma_sel_o;
  logic [31:0] dma_adr_o, dma_dat_o;
  logic        dma_ack_i;
  logic [31:0] dma_dat_i;
  logic        irq_o;

  logic        hold_en = 1'b0;
  logic [31:0] hold_adr = 32'd0;

  int checks = 0;
  int errors = 0;

  dma_copy_engine dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cfg_stb_i (cfg_stb_i),
    .cfg_cyc_i (cfg_cyc_i),
    .cfg_we_i  (cfg_we_i),
    .cfg_adr_i (cfg_adr_i),
    .cfg_dat_i (cfg_dat_i),
    .cfg_ack_o (cfg_ack_o),
    .cfg_dat_o (cfg_dat_o),
    .dma_stb_o (dma_stb_o),
    .dma_cyc_o (dma_cyc_o),
    .dma_we_o  (dma_we_o),
    .dma_sel_o (dma_sel_o),
    .dma_adr_o (dma_adr_o),
    .dma_dat_o (dma_dat_o),
    .dma_ack_i (dma_ack_i),
    .dma_dat_i (dma_dat_i),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  // Zero-wait slave; source data is {~adr[15:0], adr[15:0]}; one write address can be stalled.
  assign dma_ack_i = dma_stb_o & dma_cyc_o & ~(hold_en & dma_we_o & (dma_adr_o == hold_adr));
  assign dma_dat_i = {~dma_adr_o[15:0], dma_adr_o[15:0]};

  logic [31:0] log_adr[$];
  logic        log_we[$];
  logic [31:0] log_dat[$];
  int          gaps[$];
  int          low_run = 0;
  bit          after_ack = 1'b0;
  int          cyc_seen = 0;
  int          stall_run = 0;
  int          last_stall = 0;

  always @(negedge clk) begin
    if (dma_cyc_o) cyc_seen++;
    if (after_ack && dma_stb_o) begin
      gaps.push_back(low_run);
      after_ack = 1'b0;
    end
    if (dma_stb_o && dma_ack_i) begin
      log_adr.push_back(dma_adr_o);
      log_we.push_back(dma_we_o);
      log_dat.push_back(dma_dat_o);
      after_ack = 1'b1;
      low_run   = 0;
    end else if (after_ack) begin
      low_run++;
    end
    if (dma_stb_o && !dma_ack_i) stall_run++;
    else if (!dma_stb_o && stall_run > 0) begin
      last_stall = stall_run;
      stall_run  = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic csr_access(input logic we, input logic [3:0] a, input logic [31:0] d,
                            output logic [31:0] rd);
    int n;
    @(negedge clk);
    cfg_stb_i = 1'b1; cfg_cyc_i = 1'b1; cfg_we_i = we; cfg_adr_i = a; cfg_dat_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cfg_ack_o && n < 8);
    check("csr_ack", {31'b0, cfg_ack_o}, 32'd1);
    rd = cfg_dat_o;
    cfg_stb_i = 1'b0; cfg_cyc_i = 1'b0; cfg_we_i = 1'b0;
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    csr_access(1'b1, a, d, unused_rd);
  endtask

  task automatic csr_expect(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    csr_access(1'b0, a, 32'd0, v);
    check(tag, v, exp);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] v;
    int n;
    n = 0;
    do begin
      csr_access(1'b0, 4'h0, 32'd0, v);
      n++;
    end while (v[0] && n < 200);
    check(tag, {31'b0, v[0]}, 32'd0);
  endtask

  logic [31:0] exp_adr [6];
  int          base;
  int          base_cyc;
  int          n;

  initial begin
    rst = 1'b1;
    cfg_stb_i = 1'b0; cfg_cyc_i = 1'b0; cfg_we_i = 1'b0;
    cfg_adr_i = 4'h0; cfg_dat_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", {31'b0, dma_stb_o}, 32'd0);
    check("rst_ack", {31'b0, cfg_ack_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset values via CSR reads
    csr_expect("rst_ctrl", 4'h0, 32'h0);
    csr_expect("rst_src",  4'h4, 32'h0);
    csr_expect("rst_dst",  4'h8, 32'h0);
    csr_expect("rst_len",  4'hC, 32'h0);
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    check("rst_stb2", {31'b0, dma_stb_o}, 32'd0);

    // Three-word copy with irq enabled
    csr_write(4'h4, 32'h3800_0000);
    csr_write(4'h8, 32'h3800_0100);
    csr_write(4'hC, 32'd3);
    csr_write(4'h0, 32'h5);
    wait_idle("copy_idle");
    exp_adr = '{32'h3800_0000, 32'h3800_0100, 32'h3800_0004,
                32'h3800_0104, 32'h3800_0008, 32'h3800_0108};
    check("copy_ntx", 32'(log_adr.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("copy_adr%0d", i), log_adr[i], exp_adr[i]);
      check($sformatf("copy_we%0d", i), {31'b0, log_we[i]}, 32'(i % 2));
    end
    check("copy_dat0", log_dat[1], 32'hFFFF_0000);
    check("copy_dat1", log_dat[3], 32'hFFFB_0004);
    check("copy_dat2", log_dat[5], 32'hFFF7_0008);
    check("copy_ngaps", 32'(gaps.size()), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("copy_gap%0d", i), 32'(gaps[i]), 32'd1);
    csr_expect("copy_ctrl", 4'h0, 32'h6);
    check("copy_irq", {31'b0, irq_o}, 32'd1);
    csr_expect("copy_len", 4'hC, 32'h0);
    csr_expect("copy_src", 4'h4, 32'h3800_000C);
    csr_expect("copy_dst", 4'h8, 32'h3800_010C);

    // Zero-length start: done immediately, no bus cycle
    csr_write(4'h0, 32'h2);
    check("clr_irq", {31'b0, irq_o}, 32'd0);
    base_cyc = cyc_seen;
    csr_write(4'hC, 32'd0);
    csr_write(4'h0, 32'h1);
    csr_expect("zero_ctrl", 4'h0, 32'h2);
    check("zero_nocyc", 32'(cyc_seen - base_cyc), 32'd0);
    csr_write(4'h0, 32'h2);

    // Timeout on the second write
    hold_adr = 32'h3800_0104;
    hold_en  = 1'b1;
    base = log_adr.size();
    csr_write(4'h4, 32'h3800_0000);
    csr_write(4'h8, 32'h3800_0100);
    csr_write(4'hC, 32'd2);
    csr_write(4'h0, 32'h1);
    wait_idle("to_idle");
    csr_expect("to_ctrl", 4'h0, 32'h0A);
    csr_expect("to_len", 4'hC, 32'd1);
    csr_expect("to_dst", 4'h8, 32'h3800_0104);
    csr_expect("to_src", 4'h4, 32'h3800_0004);
    check("to_stall", 32'(last_stall), 32'd256);
    check("to_ntx", 32'(log_adr.size() - base), 32'd3);
    hold_en = 1'b0;
    csr_write(4'h0, 32'h2);
    csr_expect("to_clear", 4'h0, 32'h0);

    // Writes while busy are ignored; ie still changes
    base = log_adr.size();
    csr_write(4'h4, 32'h3800_0000);
    csr_write(4'h8, 32'h3800_0200);
    csr_write(4'hC, 32'd3);
    csr_write(4'h0, 32'h5);
    csr_write(4'h4, 32'hDEAD_BEEF);
    csr_write(4'h0, 32'h1);
    csr_expect("busy_ctrl", 4'h0, 32'h1);
    wait_idle("busy_idle");
    csr_expect("busy_done", 4'h0, 32'h2);
    check("busy_irq", {31'b0, irq_o}, 32'd0);
    csr_expect("busy_src", 4'h4, 32'h3800_000C);
    csr_expect("busy_dst", 4'h8, 32'h3800_020C);
    check("busy_ntx", 32'(log_adr.size() - base), 32'd6);
    check("busy_first", log_adr[base], 32'h3800_0000);
    check("busy_last_adr", log_adr[base + 5], 32'h3800_0208);
    check("busy_last_dat", log_dat[base + 5], 32'hFFF7_0008);

    // Source address wraps modulo 2^32; low address bits forced to 0
    csr_write(4'h0, 32'h2);
    csr_write(4'h4, 32'hFFFF_FFFF);
    csr_expect("wrap_src_wr", 4'h4, 32'hFFFF_FFFC);
    base = log_adr.size();
    csr_write(4'h8, 32'h3800_0010);
    csr_write(4'hC, 32'd1);
    csr_write(4'h0, 32'h1);
    wait_idle("wrap_idle");
    csr_expect("wrap_src", 4'h4, 32'h0);
    check("wrap_wadr", log_adr[base + 1], 32'h3800_0010);
    check("wrap_wdat", log_dat[base + 1], 32'h0003_FFFC);
    csr_expect("wrap_ctrl", 4'h0, 32'h2);

    // Asynchronous reset during a stalled write
    hold_adr = 32'h3800_0300;
    hold_en  = 1'b1;
    csr_write(4'h0, 32'h2);
    csr_write(4'h4, 32'h3800_0000);
    csr_write(4'h8, 32'h3800_0300);
    csr_write(4'hC, 32'd1);
    csr_write(4'h0, 32'h5);
    n = 0;
    while (!dma_we_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_we", {31'b0, dma_we_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_stb", {31'b0, dma_stb_o}, 32'd0);
    check("arst_cyc", {31'b0, dma_cyc_o}, 32'd0);
    check("arst_we",  {31'b0, dma_we_o}, 32'd0);
    check("arst_sel", {28'b0, dma_sel_o}, 32'd0);
    check("arst_adr", dma_adr_o, 32'd0);
    check("arst_dat", dma_dat_o, 32'd0);
    check("arst_irq", {31'b0, irq_o}, 32'd0);
    check("arst_cfgdat", cfg_dat_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hold_en = 1'b0;
    csr_expect("post_ctrl", 4'h0, 32'h0);
    csr_expect("post_src",  4'h4, 32'h0);
    csr_expect("post_dst",  4'h8, 32'h0);
    csr_expect("post_len",  4'hC, 32'h0);
    check("post_stb", {31'b0, dma_stb_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
Name:
dma_copy_engine

Overview:
- Wishbone memory-to-memory word-copy DMA master.
- Configured by the CPU through a small CSR slave port.
- Performs alternating single-word read/write transactions on its master port, which drives the arbiter's dma_* inputs.
- Inserts an idle gap after every acknowledged transaction so the arbiter can re-grant the CPU.
- Raises a level interrupt on completion or on a bus timeout.

Parameters:
- LEN_W, 16, width of the word-count register (max transfer 2^LEN_W-1 words).
- TIMEOUT, 255, maximum wait cycles for dma_ack_i per transaction before abort (must be >= 1).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- cfg_stb_i  in  1  CSR strobe.
- cfg_cyc_i  in  1  CSR cycle.
- cfg_we_i  in  1  CSR write enable.
- cfg_adr_i  in  4  CSR byte offset (bits [3:2] decode; [1:0] ignored).
- cfg_dat_i  in  32  CSR write data.
- cfg_ack_o  out  1  CSR acknowledge.
- cfg_dat_o  out  32  CSR read data.
- dma_stb_o  out  1  master strobe.
- dma_cyc_o  out  1  master cycle.
- dma_we_o  out  1  master write enable.
- dma_sel_o  out  4  byte selects.
- dma_adr_o  out  32  master address.
- dma_dat_o  out  32  master write data.
- dma_ack_i  in  1  master acknowledge (from arbiter).
- dma_dat_i  in  32  master read data.
- irq_o  out  1  interrupt, level.

Behaviour:
- Reset: clock wb_clk_i; reset wb_rst_i, asynchronous, active-high. All outputs 0. SRC, DST, LEN, buffer, timer = 0. done, err, ie = 0. FSM = IDLE.
- CSR map:
  - 0x0 CTRL. Write: bit0 start, bit1 clear done/err, bit2 ie. Read: bit0 busy, bit1 done, bit2 ie, bit3 err, others 0.
  - 0x4 SRC, 0x8 DST, 0xC LEN (LEN_W LSBs, upper bits read 0).
- SRC/DST bits[1:0] are forced to 0 on write.
- Reads return live counters during a transfer.
- CSR handshake:
  - cfg_ack_o pulses 1 cycle, registered, the cycle after stb&cyc is seen with cfg_ack_o=0, so back-to-back requests ack every other cycle.
  - cfg_dat_o is valid with ack.
  - Write side effects take effect on the ack edge.
- While busy:
  - Writes to SRC/DST/LEN are ignored (still acked).
  - CTRL start is ignored; ie may still change.
- Start and clear written in the same access: clear first, then start, so done=0 and err=0.
- Start with LEN=0: done=1 on the next cycle, no master transaction.
- Start with LEN≠0: done=0, err=0, FSM -> RD.
- FSM:
  - IDLE: all master outputs 0.
  - RD: stb=cyc=1, we=0, adr=SRC, sel=4'hF. On ack: buffer<=dma_dat_i, -> GAP1.
  - GAP1: stb=cyc=0 for exactly 1 cycle, -> WR.
  - WR: stb=cyc=1, we=1, adr=DST, dat=buffer, sel=4'hF. On ack: SRC+=4, DST+=4, LEN-=1, -> GAP2.
  - GAP2: stb=cyc=0 for 1 cycle. If LEN==0: done<=1, -> IDLE. Otherwise -> RD.
- Master outputs are registered and held stable while waiting for ack.
- Address arithmetic is modulo 2^32 (0xFFFFFFFC+4 = 0).
- Timeout:
  - The timer resets on entry to RD/WR and counts cycles without ack.
  - When the count reaches TIMEOUT, the next cycle drops stb/cyc, sets err=1 and done=1, and returns to IDLE.
  - SRC/DST/LEN keep their values at the failing word.
  - An ack arriving on the same cycle the timeout is reached counts as success.
- busy = (FSM ≠ IDLE).
- irq_o = done & ie, combinational from registers; cleared by a CTRL clear or start.
- dma_ack_i seen in IDLE/GAP states is ignored.
- Reset mid-transfer: outputs go to 0 immediately; the transfer is lost.

Test Plan:
- Reset, then read all CSRs -> CTRL=0, SRC=DST=LEN=0, irq_o=0, dma_stb_o=0.
- SRC=0x38000000, DST=0x38000100, LEN=3, CTRL=0x5, zero-wait memory model -> exact sequence:
  - R 0x38000000, W 0x38000100, R 0x38000004, W 0x38000104, R 0x38000008, W 0x38000108.
  - Data copied; stb low exactly 1 cycle after each ack.
  - Final CTRL read = 0x6, irq_o=1; LEN=0, SRC=0x3800000C.
- LEN=0, start -> CTRL read = 0x2 the cycle after the start ack, dma_cyc_o never asserted.
- LEN=2, slave withholds ack on the second write -> stb drops after TIMEOUT+1 cycles; CTRL=0x0A; LEN=1, DST=0x..104. Writing CTRL=0x2 then clears to 0x0.
- During busy, write SRC=0xDEADBEEF and CTRL=0x1 -> SRC readback unchanged, transfer unaffected, no restart.
- Reset asserted in the middle of a WR transaction -> all outputs 0 asynchronously; after release all CSRs read 0.
